// File: rtl/sa_matmul.sv
// rtl/sa_matmul.sv - weight-stationary systolic C = A*B engine with register-array memories
// Define SA_MATMUL_SIGNED_EN for two's-complement arithmetic; unsigned otherwise.

module sa_mem #(
    parameter int EW    = 8,
    parameter int ELEMS = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic [ELEMS-1:0]    wr_en,
    input  logic [ELEMS*AW-1:0] wr_addr,
    input  logic [ELEMS*EW-1:0] wr_data,
    input  logic [ELEMS*AW-1:0] rd_addr,
    output logic [ELEMS*EW-1:0] rd_data
);
    // Each element lane has its own row address so skewed rows can be touched in one cycle.
    logic [ELEMS*EW-1:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        for (int e = 0; e < ELEMS; e++) begin
            if (wr_en[e])
                mem_array[wr_addr[e*AW +: AW]][e*EW +: EW] <= wr_data[e*EW +: EW];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int e = 0; e < ELEMS; e++)
            rd_data[e*EW +: EW] = mem_array[rd_addr[e*AW +: AW]][e*EW +: EW];
    end
endmodule

module sa_ctrl #(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int NUM_INPUTS = 4,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic          o_done,
    output logic          load_w,
    output logic          compute,
    output logic [CW-1:0] count
);
    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DONE} state_t;

    state_t        curr_state;
    logic [CW-1:0] count_r;

    assign count   = count_r;
    assign load_w  = (curr_state == LOAD_W);
    assign compute = (curr_state == COMPUTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_state <= IDLE;
            count_r    <= '0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (curr_state)
                IDLE: begin
                    count_r <= '0;
                    if (i_start)
                        curr_state <= LOAD_W;
                end
                LOAD_W: begin
                    if (count_r == CW'(NUM_ROWS - 1)) begin
                        curr_state <= COMPUTE;
                        count_r    <= '0;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (count_r == CW'(NUM_INPUTS + NUM_ROWS + NUM_COLS - 1)) begin
                        curr_state <= DONE;
                        count_r    <= '0;
                        o_done     <= 1'b1;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                default: curr_state <= IDLE;
            endcase
        end
    end
endmodule

module sa_pe_array #(
    parameter int ADD_DATAWIDTH = 8,
    parameter int MUL_DATAWIDTH = 8,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_w,
    input  logic [NUM_COLS*MUL_DATAWIDTH-1:0] w_row,
    input  logic [NUM_ROWS*MUL_DATAWIDTH-1:0] act_col,
    output logic [NUM_COLS*ADD_DATAWIDTH-1:0] psum_bottom
);
    localparam int PW = MUL_DATAWIDTH + ADD_DATAWIDTH;

    logic [MUL_DATAWIDTH-1:0] systolic_inputs  [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0] systolic_weights [NUM_ROWS][NUM_COLS];
    logic [ADD_DATAWIDTH-1:0] systolic_psums   [NUM_ROWS][NUM_COLS];
    logic [ADD_DATAWIDTH-1:0] systolic_outputs [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0] act_in           [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0] w_in             [NUM_ROWS][NUM_COLS];

    // Low ADD_DATAWIDTH bits of the product only depend on the extended operands' low bits.
    function automatic logic [ADD_DATAWIDTH-1:0] mac(
        input logic [ADD_DATAWIDTH-1:0] psum,
        input logic [MUL_DATAWIDTH-1:0] act,
        input logic [MUL_DATAWIDTH-1:0] wgt
    );
        logic [PW-1:0]            act_x;
        logic [PW-1:0]            wgt_x;
        logic [ADD_DATAWIDTH-1:0] prod;
`ifdef SA_MATMUL_SIGNED_EN
        act_x = {{(PW-MUL_DATAWIDTH){act[MUL_DATAWIDTH-1]}}, act};
        wgt_x = {{(PW-MUL_DATAWIDTH){wgt[MUL_DATAWIDTH-1]}}, wgt};
`else
        act_x = {{(PW-MUL_DATAWIDTH){1'b0}}, act};
        wgt_x = {{(PW-MUL_DATAWIDTH){1'b0}}, wgt};
`endif
        prod = ADD_DATAWIDTH'(act_x * wgt_x);
        return psum + prod;
    endfunction

    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_row
        for (genvar n = 0; n < NUM_COLS; n++) begin : g_col
            if (n == 0) begin : g_left
                assign act_in[k][n] = act_col[k*MUL_DATAWIDTH +: MUL_DATAWIDTH];
            end else begin : g_inner
                assign act_in[k][n] = systolic_inputs[k][n-1];
            end

            if (k == 0) begin : g_top
                assign systolic_psums[k][n] = '0;
                assign w_in[k][n]           = w_row[n*MUL_DATAWIDTH +: MUL_DATAWIDTH];
            end else begin : g_below
                assign systolic_psums[k][n] = systolic_outputs[k-1][n];
                assign w_in[k][n]           = systolic_weights[k-1][n];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    systolic_inputs[k][n]  <= '0;
                    systolic_weights[k][n] <= '0;
                    systolic_outputs[k][n] <= '0;
                end else begin
                    systolic_inputs[k][n]  <= act_in[k][n];
                    systolic_outputs[k][n] <= mac(systolic_psums[k][n], systolic_inputs[k][n],
                                                  systolic_weights[k][n]);
                    if (load_w)
                        systolic_weights[k][n] <= w_in[k][n];
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_COLS; n++) begin : g_bottom
        assign psum_bottom[n*ADD_DATAWIDTH +: ADD_DATAWIDTH] = systolic_outputs[NUM_ROWS-1][n];
    end
endmodule

module sa_matmul #(
    parameter int ADD_DATAWIDTH = 8,
    parameter int MUL_DATAWIDTH = 8,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4,
    parameter int NUM_INPUTS    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_done
);
    localparam int CW  = $clog2(NUM_INPUTS + NUM_ROWS + NUM_COLS);
    localparam int IAW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int WAW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic                              load_w;
    logic                              compute;
    logic [CW-1:0]                     count;
    logic [NUM_ROWS*IAW-1:0]           in_rd_addr;
    logic [NUM_ROWS*MUL_DATAWIDTH-1:0] in_rd_data;
    logic [NUM_ROWS*MUL_DATAWIDTH-1:0] act_col;
    logic [WAW-1:0]                    w_addr;
    logic [NUM_COLS*WAW-1:0]           w_rd_addr;
    logic [NUM_COLS*MUL_DATAWIDTH-1:0] w_row;
    logic [NUM_COLS-1:0]               out_wr_en;
    logic [NUM_COLS*IAW-1:0]           out_wr_addr;
    logic [NUM_COLS*ADD_DATAWIDTH-1:0] psum_bottom;
    logic [NUM_COLS*ADD_DATAWIDTH-1:0] out_rd_unused;

    sa_ctrl #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .NUM_INPUTS(NUM_INPUTS), .CW(CW))
    sys_array_ctrl (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_done(o_done),
        .load_w(load_w), .compute(compute), .count(count)
    );

    sa_mem #(.EW(MUL_DATAWIDTH), .ELEMS(NUM_ROWS), .DEPTH(NUM_INPUTS), .AW(IAW)) input_mem (
        .clk(clk), .wr_en('0), .wr_addr('0), .wr_data('0),
        .rd_addr(in_rd_addr), .rd_data(in_rd_data)
    );

    sa_mem #(.EW(MUL_DATAWIDTH), .ELEMS(NUM_COLS), .DEPTH(NUM_ROWS), .AW(WAW)) weight_mem (
        .clk(clk), .wr_en('0), .wr_addr('0), .wr_data('0),
        .rd_addr(w_rd_addr), .rd_data(w_row)
    );

    sa_mem #(.EW(ADD_DATAWIDTH), .ELEMS(NUM_COLS), .DEPTH(NUM_INPUTS), .AW(IAW)) output_mem (
        .clk(clk), .wr_en(out_wr_en), .wr_addr(out_wr_addr), .wr_data(psum_bottom),
        .rd_addr('0), .rd_data(out_rd_unused)
    );

    sa_pe_array #(
        .ADD_DATAWIDTH(ADD_DATAWIDTH), .MUL_DATAWIDTH(MUL_DATAWIDTH),
        .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)
    ) sys_array (
        .clk(clk), .rst_n(rst_n), .load_w(load_w),
        .w_row(w_row), .act_col(act_col), .psum_bottom(psum_bottom)
    );

    // Bottom weight row is fed first so row k ends up holding B[k] after NUM_ROWS shifts.
    assign w_addr = WAW'(NUM_ROWS - 1) - count[WAW-1:0];

    for (genvar n = 0; n < NUM_COLS; n++) begin : g_wr_addr
        assign w_rd_addr[n*WAW +: WAW] = w_addr;
    end

    // A negative row index wraps to at least NUM_INPUTS, so one compare gates both ends.
    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_feed
        logic [CW-1:0] a_row;
        assign a_row = count - CW'(k);
        assign in_rd_addr[k*IAW +: IAW] = a_row[IAW-1:0];
        assign act_col[k*MUL_DATAWIDTH +: MUL_DATAWIDTH] =
            (compute && (a_row < CW'(NUM_INPUTS))) ? in_rd_data[k*MUL_DATAWIDTH +: MUL_DATAWIDTH] : '0;
    end

    // Column n emits C[m][n] NUM_ROWS+n+1 cycles after A row m enters the array.
    for (genvar n = 0; n < NUM_COLS; n++) begin : g_drain
        logic [CW-1:0] c_row;
        assign c_row = count - CW'(n + NUM_ROWS + 1);
        assign out_wr_en[n] = compute && (c_row < CW'(NUM_INPUTS));
        assign out_wr_addr[n*IAW +: IAW] = c_row[IAW-1:0];
    end
endmodule

// File: tb/tb_sa_matmul.sv
// tb/tb_sa_matmul.sv - randomized scoreboard bench for sa_matmul against a matrix-product model

module tb_sa_matmul;
    localparam int AW  = 8;
    localparam int MW  = 8;
    localparam int K   = 4;
    localparam int N   = 4;
    localparam int M   = 4;
    localparam int LAT = 2*K + M + N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic o_done;

    sa_matmul dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int checks = 0;
    int failures = 0;

    logic [MW-1:0] a_m [M][K];
    logic [MW-1:0] b_m [K][N];

    logic [M*N*AW-1:0] exp_c_q [$];
    int                exp_edge_q [$];
    logic [M*N*AW-1:0] mon_c;
    int                mon_edge;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sx(input logic [MW-1:0] x);
`ifdef SA_MATMUL_SIGNED_EN
        return x[MW-1] ? int'(x) - (1 << MW) : int'(x);
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [M*N*AW-1:0] model();
        logic [M*N*AW-1:0] c;
        logic [31:0]       s;
        c = '0;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int k = 0; k < K; k++)
                    s = s + 32'(sx(a_m[m][k]) * sx(b_m[k][n]));
                c[(m*N+n)*AW +: AW] = s[AW-1:0];
            end
        return c;
    endfunction

    function automatic logic [K*MW-1:0] a_row(input int m);
        logic [K*MW-1:0] r;
        for (int k = 0; k < K; k++) r[k*MW +: MW] = a_m[m][k];
        return r;
    endfunction

    function automatic logic [N*MW-1:0] b_row(input int k);
        logic [N*MW-1:0] r;
        for (int n = 0; n < N; n++) r[n*MW +: MW] = b_m[k][n];
        return r;
    endfunction

    task automatic set_pattern(input int kind);
        for (int m = 0; m < M; m++)
            for (int k = 0; k < K; k++)
                case (kind)
                    0:       a_m[m][k] = (m == k) ? MW'(1) : MW'(0);
                    1:       a_m[m][k] = MW'(7);
                    2:       a_m[m][k] = MW'(8'h80);
                    3:       a_m[m][k] = MW'(8'hFF);
                    default: a_m[m][k] = MW'($urandom());
                endcase
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                case (kind)
                    0:       b_m[k][n] = MW'(4*k + n);
                    1:       b_m[k][n] = MW'(7);
                    2:       b_m[k][n] = MW'(2);
                    3:       b_m[k][n] = MW'(3);
                    default: b_m[k][n] = MW'($urandom());
                endcase
    endtask

    task automatic load_mats();
        for (int m = 0; m < M; m++) dut.input_mem.mem_array[m] <= a_row(m);
        for (int k = 0; k < K; k++) dut.weight_mem.mem_array[k] <= b_row(k);
        @(negedge clk);
    endtask

    task automatic start_op(input int hold);
        @(negedge clk);
        i_start = 1'b1;
        exp_c_q.push_back(model());
        exp_edge_q.push_back(edge_cnt + 1 + LAT);
        repeat (hold) @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_drain();
        int i = 0;
        while (exp_c_q.size() != 0 && i < 4*LAT) begin
            @(negedge clk);
            i++;
        end
        chk("drain_done_pulse", exp_c_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every o_done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            chk("done_expected", exp_c_q.size() > 0, 1'b1);
            if (exp_c_q.size() > 0) begin
                mon_c    = exp_c_q.pop_front();
                mon_edge = exp_edge_q.pop_front();
                chk("done_edge", edge_cnt, mon_edge);
                for (int m = 0; m < M; m++)
                    for (int n = 0; n < N; n++)
                        chk($sformatf("c_m%0d_n%0d", m, n),
                            dut.output_mem.mem_array[m][n*AW +: AW],
                            mon_c[(m*N+n)*AW +: AW]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(dut.sys_array_ctrl.curr_state), 0);
        chk("rst_count", dut.sys_array_ctrl.count_r, 0);
        chk("rst_done", o_done, 0);
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                chk($sformatf("rst_psum_k%0d_n%0d", k, n), dut.sys_array.systolic_outputs[k][n], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed patterns: identity, all-7, wrap with a held start, all -1 times 3.
        for (int p = 0; p < 4; p++) begin
            set_pattern(p);
            load_mats();
            start_op(p == 2 ? 10 : 1);
            wait_drain();
        end

        // Weights must be stationary in place once LOAD_W completes.
        set_pattern(9);
        load_mats();
        start_op(1);
        repeat (K + 1) @(negedge clk);
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                chk($sformatf("weight_k%0d_n%0d", k, n), dut.sys_array.systolic_weights[k][n], b_m[k][n]);
        wait_drain();

        // Reset mid-COMPUTE aborts without a done pulse and keeps memory contents.
        set_pattern(9);
        load_mats();
        start_op(1);
        repeat (K + 3) @(negedge clk);
        chk("abort_in_compute", int'(dut.sys_array_ctrl.curr_state), 2);
        rst_n = 1'b0;
        exp_c_q.delete();
        exp_edge_q.delete();
        #1;
        chk("abort_state", int'(dut.sys_array_ctrl.curr_state), 0);
        chk("abort_count", dut.sys_array_ctrl.count_r, 0);
        chk("abort_done", o_done, 0);
        for (int k = 0; k < K; k++)
            chk($sformatf("abort_weight_k%0d", k), dut.sys_array.systolic_weights[k][N-1], 0);
        chk("abort_input_mem_kept", dut.input_mem.mem_array[M-1], a_row(M-1));
        chk("abort_weight_mem_kept", dut.weight_mem.mem_array[0], b_row(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        set_pattern(9);
        load_mats();
        start_op(1);
        wait_drain();

        for (int r = 0; r < 6; r++) begin
            set_pattern(9);
            load_mats();
            start_op(1 + (r % 3));
            wait_drain();
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sa_matmul.md
SA_MATMUL -- requirements
Module: sa_matmul

Interface
REQ-001 Parameter ADD_DATAWIDTH, default 8, SHALL set the partial-sum / output element width.
REQ-002 Parameter MUL_DATAWIDTH, default 8, SHALL set the activation and weight element width.
REQ-003 Parameter NUM_ROWS, default 4, SHALL set the array height K (the reduction dimension).
REQ-004 Parameter NUM_COLS, default 4, SHALL set the array width N (the output columns).
REQ-005 Parameter NUM_INPUTS, default 4, SHALL set the streaming dimension M (activation rows).
REQ-006 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 i_start  input  1  SHALL request one C = A*B operation when sampled high in IDLE.
REQ-009 o_done  output  1  SHALL be a registered, one-cycle completion pulse.

Function
REQ-010 Memories SHALL be plain register arrays named mem_array in instances input_mem (NUM_INPUTS x NUM_ROWS*MUL_DATAWIDTH), weight_mem (NUM_ROWS x NUM_COLS*MUL_DATAWIDTH) and output_mem (NUM_INPUTS x NUM_COLS*ADD_DATAWIDTH), loadable/dumpable by hierarchical $readmemh/$writememh.
REQ-011 Within each word, element index 0 SHALL occupy the least-significant bits; input_mem row m = A[m][0..K-1], weight_mem row k = B[k][0..N-1], output_mem row m = C[m][0..N-1].
REQ-012 Controller instance sys_array_ctrl SHALL hold curr_state (enum IDLE, LOAD_W, COMPUTE, DONE) and a cycle counter count_r.
REQ-013 IDLE -> LOAD_W when i_start=1; i_start SHALL be ignored in all other states.
REQ-014 LOAD_W SHALL last exactly NUM_ROWS cycles, shifting weight_mem rows down the array so PE[k][n] holds B[k][n] when it ends; then -> COMPUTE.
REQ-015 COMPUTE SHALL last exactly NUM_INPUTS+NUM_ROWS+NUM_COLS cycles; array row k SHALL receive A[m][k] at compute cycle m+k (skewed), activations moving right and partial sums moving down (weight-stationary).
REQ-016 Each bottom-row column-n result C[m][n] SHALL be written to output_mem row m, element n, before COMPUTE ends; then -> DONE.
REQ-017 DONE SHALL last one cycle with o_done=1, then -> IDLE; o_done SHALL be 0 in all other states.
REQ-018 With clock edge E0 sampling i_start, o_done SHALL be high in the cycle following edge E0+2*NUM_ROWS+NUM_INPUTS+NUM_COLS (16 edges for defaults).
REQ-019 Array instance sys_array SHALL expose per-PE 2-D arrays systolic_inputs, systolic_weights, systolic_psums, systolic_outputs indexed [row][col].
REQ-020 Each PE SHALL compute psum_out = psum_in + act*weight; products SHALL be truncated to ADD_DATAWIDTH and sums SHALL wrap modulo 2^ADD_DATAWIDTH; top-row psum_in = 0.
REQ-021 output_mem rows SHALL be fully overwritten by every operation; input_mem and weight_mem SHALL never be written by the block.

Reset
REQ-022 rst_n low SHALL immediately force curr_state=IDLE, count_r=0, o_done=0, and clear all PE weight, activation and psum registers.
REQ-023 Reset SHALL NOT clear any mem_array contents; reset mid-operation SHALL abort with no o_done and leave partially written output_mem.

Configuration
REQ-024 With macro SA_MATMUL_SIGNED_EN defined, activations, weights and partial sums SHALL be two's-complement signed (sign-extended before accumulate); without it, all arithmetic SHALL be unsigned.

Verification
REQ-025 Load A=identity, B[k][n]=4k+n, pulse i_start -> output_mem equals B (row0 = 00,01,02,03), o_done at edge 16.
REQ-026 Load A and B all 7 (defaults, unsigned) -> every C element = 0xC4 (196).
REQ-027 Weights-only check: pulse i_start, after NUM_ROWS+2 cycles -> systolic_weights[k][n] = B[k][n].
REQ-028 Assert rst_n low during COMPUTE -> state IDLE, o_done never pulses, new i_start then completes correctly.
REQ-029 Hold i_start high for 10 cycles -> exactly one o_done pulse per IDLE entry; A=all 0x80, B=all 0x02 unsigned -> C = 0x00 (wrap).
REQ-030 SA_MATMUL_SIGNED_EN defined, A all 0xFF (-1), B all 0x03 -> every C element = 0xF4 (-12).
